// File: rtl/key_event_decoder.sv
// rtl/key_event_decoder.sv - debounced key level to press/release/short/long/repeat event pulses
// Optional auto-repeat is built only when KEY_REPEAT_EN is defined.
module key_event_decoder #(
   parameter int CNT_W      = 26,
   parameter int LONG_CNT   = 50_000_000,
   parameter int REPEAT_CNT = 10_000_000,
   parameter int ACTIVE_LOW = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic key_in,
   output logic press_pulse,
   output logic release_pulse,
   output logic short_pulse,
   output logic long_pulse,
   output logic repeat_pulse,
   output logic key_held
);

   typedef enum logic [1:0] {IDLE, PRESSED, LONG} state_t;

   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);

   if (LONG_CNT < 2 || REPEAT_CNT < 1) begin : g_param_check
      $error("key_event_decoder: LONG_CNT must be >= 2 and REPEAT_CNT >= 1");
   end

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             p, p_q;
   logic             press_nxt, release_nxt, short_nxt, long_nxt;

   assign p = (ACTIVE_LOW != 0) ? ~key_in : key_in;

`ifdef KEY_REPEAT_EN
   localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CNT - 1);
   logic repeat_nxt;
   logic repeat_q;
   assign repeat_pulse = repeat_q;
`else
   assign repeat_pulse = 1'b0;
`endif

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      press_nxt   = 1'b0;
      release_nxt = 1'b0;
      short_nxt   = 1'b0;
      long_nxt    = 1'b0;
`ifdef KEY_REPEAT_EN
      repeat_nxt  = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (p && !p_q) begin
               state_nxt = PRESSED;
               cnt_nxt   = '0;
               press_nxt = 1'b1;
            end
         end
         PRESSED: begin
            // Release is checked first so it wins over a coincident long threshold.
            if (!p) begin
               state_nxt   = IDLE;
               cnt_nxt     = '0;
               release_nxt = 1'b1;
               short_nxt   = 1'b1;
            end else if (cnt == LONG_LAST) begin
               state_nxt = LONG;
               cnt_nxt   = '0;
               long_nxt  = 1'b1;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         LONG: begin
            if (!p) begin
               state_nxt   = IDLE;
               cnt_nxt     = '0;
               release_nxt = 1'b1;
            end else begin
`ifdef KEY_REPEAT_EN
               if (cnt == REP_LAST) begin
                  cnt_nxt    = '0;
                  repeat_nxt = 1'b1;
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
`endif
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // p_q resets to 1 so a key held through reset must be released before it counts as pressed.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         cnt           <= '0;
         p_q           <= 1'b1;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         short_pulse   <= 1'b0;
         long_pulse    <= 1'b0;
         key_held      <= 1'b0;
`ifdef KEY_REPEAT_EN
         repeat_q      <= 1'b0;
`endif
      end else begin
         state         <= state_nxt;
         cnt           <= cnt_nxt;
         p_q           <= p;
         press_pulse   <= press_nxt;
         release_pulse <= release_nxt;
         short_pulse   <= short_nxt;
         long_pulse    <= long_nxt;
         key_held      <= (state_nxt != IDLE);
`ifdef KEY_REPEAT_EN
         repeat_q      <= repeat_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_key_event_decoder.sv
// tb/tb_key_event_decoder.sv - scoreboard bench for key_event_decoder (LONG_CNT=8, REPEAT_CNT=4, active-low)
module tb_key_event_decoder;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic key_in = 1'b1;
   logic press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse, key_held;

   key_event_decoder #(
      .CNT_W(26), .LONG_CNT(8), .REPEAT_CNT(4), .ACTIVE_LOW(1)
   ) dut (
      .clk(clk), .rst(rst), .key_in(key_in),
      .press_pulse(press_pulse), .release_pulse(release_pulse),
      .short_pulse(short_pulse), .long_pulse(long_pulse),
      .repeat_pulse(repeat_pulse), .key_held(key_held)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // event bits: {press, release, short, long, repeat}
   localparam logic [4:0] E_PRESS = 5'b10000;
   localparam logic [4:0] E_REL   = 5'b01000;
   localparam logic [4:0] E_SHORT = 5'b00100;
   localparam logic [4:0] E_LONG  = 5'b00010;
   localparam logic [4:0] E_REP   = 5'b00001;

   typedef struct {
      int         cyc;
      logic [4:0] ev;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;

   function automatic void push(input int c, input logic [4:0] ev);
      exp_t e;
      e.cyc = c;
      e.ev  = ev;
      q.push_back(e);
   endfunction

   task automatic chk(input string name, input logic [5:0] got, input logic [5:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, got, want);
      end
   endtask

   // Monitor: pops an expectation whenever any pulse is seen; also flags expectations that went stale.
   always @(negedge clk) begin
      logic [4:0] ev;
      exp_t       e;
      ev = {press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse};
      while (q.size() != 0 && q[0].cyc < cyc) begin
         e = q.pop_front();
         total++;
         bad++;
         $display("FAIL missed_event cyc=%0d got=none want=%b@%0d", cyc, e.ev, e.cyc);
      end
      if (ev != 5'b0) begin
         total++;
         if (q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event cyc=%0d got=%b want=none", cyc, ev);
         end else begin
            e = q.pop_front();
            if (e.cyc != cyc || e.ev != ev) begin
               bad++;
               $display("FAIL event cyc=%0d got=%b want=%b@%0d", cyc, ev, e.ev, e.cyc);
            end
         end
      end
   end

   // Press for n samples then release; expected timeline is relative to the cycle key_in falls.
   task automatic press_for(input int n);
      int c;
      @(negedge clk);
      key_in = 1'b0;
      c = cyc;
      push(c + 1, E_PRESS);
      if (n >= 9) begin
         push(c + 9, E_LONG);
`ifdef KEY_REPEAT_EN
         for (int t = c + 13; t <= c + n; t += 4) push(t, E_REP);
`endif
         push(c + n + 1, E_REL);
      end else begin
         push(c + n + 1, E_REL | E_SHORT);
      end
      for (int i = 1; i <= n; i++) begin
         @(negedge clk);
         if (i == 1) chk("held_on_press", {5'b0, key_held}, 6'b000001);
         if (i == n) key_in = 1'b1;
      end
      @(negedge clk);
      chk("held_after_release", {5'b0, key_held}, 6'b0);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int c;
      repeat (3) @(negedge clk);
      chk("reset_outputs",
          {press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse, key_held}, 6'b0);
      rst = 1'b0;

      // basic short press, long hold (with repeats when built), race at threshold, 1-cycle, just-long
      repeat (5) @(negedge clk);
      press_for(3);
      press_for(20);
      press_for(8);
      press_for(1);
      press_for(9);

      // key held through reset: no press until released and pressed again
      @(negedge clk);
      rst = 1'b1;
      key_in = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("reset_held_outputs",
             {press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse, key_held}, 6'b0);
      end
      rst = 1'b0;
      repeat (6) @(negedge clk);
      chk("no_press_after_reset", {5'b0, key_held}, 6'b0);
      key_in = 1'b1;
      repeat (3) @(negedge clk);
      press_for(2);

      // reset while in LONG: outputs clear at once, no release, no spurious press
      @(negedge clk);
      key_in = 1'b0;
      c = cyc;
      push(c + 1, E_PRESS);
      push(c + 9, E_LONG);
      repeat (11) @(negedge clk);
      chk("held_in_long", {5'b0, key_held}, 6'b000001);
      rst = 1'b1;
      @(negedge clk);
      chk("reset_mid_hold",
          {press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse, key_held}, 6'b0);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      chk("idle_after_mid_reset", {5'b0, key_held}, 6'b0);
      key_in = 1'b1;
      repeat (4) @(negedge clk);
      press_for(3);

      repeat (3) @(negedge clk);
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL pending_expectations got=%0d want=0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
